ahb_sram_slave: RTL

- Synthesizable AHB-Lite responder that fronts the single-port synchronous SRAM macro (active-low cen/wen/ben) used by the core.
- Accepts pipelined AHB-Lite transfers from the core's master port, inserts a configurable number of read wait states, and returns two-cycle ERROR responses for illegal transfers.
- Replaces the behavioural memory slave in benches and in the integrated top.

---
 rtl/ahb_sram_slave_if.sv | 23 ++
 rtl/ahb_sram_slave.sv | 119 +++++++++++
 2 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite transfer signals between the core's master port (plus bus-level HREADY) and the SRAM responder.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder for the single-port SRAM macro: zero-wait writes, LATENCY-cycle reads, two-cycle ERROR.
// Stalls the bus via HREADYOUT only in read/error data phases; AHB_SRAM_MISALIGN_ERR_EN makes misaligned half/word an ERROR.
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned LATENCY   = 2
) (
  input  logic            HCLK,
  input  logic            HRESET,
  ahb_sram_slave_if.slave bus,
  output logic            sram_cen,
  output logic            sram_wen,
  output logic [3:0]      sram_ben,
  output logic [31:0]     sram_addr,
  output logic [31:0]     sram_din,
  input  logic [31:0]     sram_dout
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, ERR1, ERR2} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        ready_q;
  logic        resp_q;
  logic [31:0] rdata_q;
  logic        cen_q;
  logic        wen_q;
  logic [3:0]  ben_q;
  logic [31:0] addr_q;

  logic        accept;
  logic [31:0] offset;
  logic        out_of_range;
  logic        misaligned;
  logic        illegal;
  logic [3:0]  lanes;

  assign accept       = bus.HSEL & bus.HTRANS[1] & bus.HREADYIN;
  assign offset       = bus.HADDR - BASE_ADDR;
  assign out_of_range = (bus.HADDR < BASE_ADDR) || (offset >= 32'(MEM_BYTES));

`ifdef AHB_SRAM_MISALIGN_ERR_EN
  assign misaligned = ((bus.HSIZE == 3'd1) && offset[0]) ||
                      ((bus.HSIZE == 3'd2) && (offset[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign illegal = out_of_range || (bus.HSIZE > 3'd2) || misaligned;

  always_comb begin
    lanes = 4'hF;
    case (bus.HSIZE)
      3'd0:    lanes[offset[1:0]] = 1'b0;
      3'd1:    lanes = offset[1] ? 4'b0011 : 4'b1100;
      default: lanes = 4'b0000;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      ben_q   <= 4'hF;
      addr_q  <= '0;
    end else begin
      cen_q <= 1'b1;
      wen_q <= 1'b1;
      ben_q <= 4'hF;
      // SRAM read data is ready at the end of the access cycle
      if (!cen_q && wen_q) rdata_q <= sram_dout;
      if (!ready_q) begin
        case (state)
          ERR1:    begin state <= ERR2; ready_q <= 1'b1; end
          RD_WAIT: begin cnt <= cnt - 3'd1; ready_q <= (cnt == 3'd1); end
          default: ready_q <= 1'b1;
        endcase
      end else if (accept && illegal) begin
        state   <= ERR1;
        ready_q <= 1'b0;
        resp_q  <= 1'b1;
      end else if (accept && !bus.HWRITE) begin
        state   <= RD_WAIT;
        cnt     <= 3'(LATENCY - 1);
        ready_q <= (LATENCY == 1);
        resp_q  <= 1'b0;
        cen_q   <= 1'b0;
        addr_q  <= {offset[31:2], 2'b00};
      end else if (accept) begin
        state   <= IDLE;
        ready_q <= 1'b1;
        resp_q  <= 1'b0;
        cen_q   <= 1'b0;
        wen_q   <= 1'b0;
        ben_q   <= lanes;
        addr_q  <= {offset[31:2], 2'b00};
      end else begin
        state   <= IDLE;
        ready_q <= 1'b1;
        resp_q  <= 1'b0;
      end
    end
  end

  // Reset masks the registered strobes so no access escapes during a reset cycle
  assign sram_cen  = cen_q | HRESET;
  assign sram_wen  = wen_q | HRESET;
  assign sram_ben  = ben_q | {4{HRESET}};
  assign sram_addr = addr_q;
  assign sram_din  = (!cen_q && !wen_q && !HRESET) ? bus.HWDATA : 32'h0;

  assign bus.HREADYOUT = ready_q;
  assign bus.HRESP     = resp_q;
  assign bus.HRDATA    = ((LATENCY == 1) && (state == RD_WAIT)) ? sram_dout : rdata_q;
endmodule
